// File: rtl/fan_pkg.sv
// Shared constants and state encoding for the fan PWM driver.
package fan_pkg;

    localparam int unsigned SPEED_W   = 4;
    localparam int unsigned PWM_STEPS = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } fan_state_e;

endpackage

// File: rtl/fan_pwm_timebase.sv
// Free-running PWM timebase: prescaler, 16-step PWM counter, period boundary strobe.
module fan_pwm_timebase
    import fan_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [SPEED_W-1:0] pwm_cnt,
    output logic               pb
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(PRESCALE - 1));
    assign pb   = tick && (pwm_cnt == SPEED_W'(PWM_STEPS - 1));

    // Prescaler wraps to produce a tick; the PWM counter advances on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + SPEED_W'(1);
        end else begin
            presc   <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan motor PWM driver with start-up kick and slew-limited speed ramping.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned RAMP_PERIODS = 2,
    parameter int unsigned KICK_PERIODS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SPEED_W-1:0] crs_tgt,
    output logic               pwm,
    output logic [SPEED_W-1:0] cur_speed,
    output logic [1:0]         state,
    output logic               at_target
);

    localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam int unsigned RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic [SPEED_W-1:0] pwm_cnt;
    logic               pb;

    fan_state_e         state_q,   state_nxt;
    logic [SPEED_W-1:0] tgt,       tgt_nxt;
    logic [SPEED_W-1:0] cur_nxt;
    logic [KW-1:0]      kick_cnt,  kick_nxt;
    logic [RW-1:0]      ramp_cnt,  ramp_nxt;
    logic               pwm_nxt;
    logic               at_target_nxt;

    fan_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .pb      (pb)
    );

    assign state = state_q;

    // State, speed and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            tgt       <= '0;
            cur_speed <= '0;
            kick_cnt  <= '0;
            ramp_cnt  <= '0;
            pwm       <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            tgt       <= tgt_nxt;
            cur_speed <= cur_nxt;
            kick_cnt  <= kick_nxt;
            ramp_cnt  <= ramp_nxt;
            pwm       <= pwm_nxt;
            at_target <= at_target_nxt;
        end
    end

    // Next-state: target sampling, kick sequencing and ramping, all gated to period boundaries.
    always_comb begin
        tgt_nxt   = pb ? crs_tgt : tgt;
        state_nxt = state_q;
        cur_nxt   = cur_speed;
        kick_nxt  = kick_cnt;
        ramp_nxt  = ramp_cnt;

        if (!en) begin
            state_nxt = ST_OFF;
            cur_nxt   = '0;
            kick_nxt  = '0;
            ramp_nxt  = '0;
        end else if (pb) begin
            case (state_q)
                ST_OFF: begin
                    if (tgt_nxt != SPEED_W'(0)) begin
                        state_nxt = ST_KICK;
                        kick_nxt  = '0;
                    end
                end
                ST_KICK: begin
                    if (tgt_nxt == SPEED_W'(0)) begin
                        state_nxt = ST_OFF;
                        kick_nxt  = '0;
                    end else if (kick_cnt == KW'(KICK_PERIODS - 1)) begin
                        state_nxt = ST_RUN;
                        cur_nxt   = tgt_nxt;
                        kick_nxt  = '0;
                        ramp_nxt  = '0;
                    end else begin
                        kick_nxt  = kick_cnt + KW'(1);
                    end
                end
                ST_RUN: begin
                    if (cur_speed == SPEED_W'(0) && tgt_nxt == SPEED_W'(0)) begin
                        state_nxt = ST_OFF;
                        ramp_nxt  = '0;
                    end else if (cur_speed == tgt_nxt) begin
                        ramp_nxt  = '0;
                    end else if (ramp_cnt == RW'(RAMP_PERIODS - 1)) begin
                        cur_nxt   = (cur_speed < tgt_nxt) ? cur_speed + SPEED_W'(1)
                                                          : cur_speed - SPEED_W'(1);
                        ramp_nxt  = '0;
                    end else begin
                        ramp_nxt  = ramp_cnt + RW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cur_nxt   = '0;
                    kick_nxt  = '0;
                    ramp_nxt  = '0;
                end
            endcase
        end

        pwm_nxt       = en && ((state_q == ST_KICK) ||
                               (state_q == ST_RUN && pwm_cnt < cur_speed));
        at_target_nxt = (state_nxt == ST_RUN) && (cur_nxt == tgt_nxt);
    end

endmodule
